// File: rtl/spi_master_cfg_if.sv
// Host and SPI pin bundle for spi_master_cfg; signal names follow the block's pin list.
// The master modport is the DUT view, the slave modport is the host/bench view.
interface spi_master_cfg_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CS = 1,
   parameter int unsigned CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
   logic              start;
   logic              cpol;
   logic              cpha;
   logic [CSW-1:0]    cs_sel;
   logic [DATA_W-1:0] din_master;
   logic [DATA_W-1:0] dout_master;
   logic              busy;
   logic              done;
   logic              miso;
   logic              mosi;
   logic              sclk;
   logic [NUM_CS-1:0] cs_n;

   modport master (
      input  start, cpol, cpha, cs_sel, din_master, miso,
      output dout_master, busy, done, mosi, sclk, cs_n
   );

   modport slave (
      output start, cpol, cpha, cs_sel, din_master, miso,
      input  dout_master, busy, done, mosi, sclk, cs_n
   );
endinterface

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master, one DATA_W-bit full-duplex word per start, all CPOL/CPHA modes.
// Optional SPI_LOOPBACK_EN: received bits are taken from the internal mosi instead of miso.
module spi_master_cfg #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned NUM_CS  = 1
) (
   input  logic              mclk,
   input  logic              rst,
   spi_master_cfg_if.master  bus
);
   localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int unsigned CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned EW  = $clog2(2 * DATA_W + 1);
   localparam logic [CW-1:0] DivLast  = CW'(CLK_DIV - 1);
   localparam logic [EW-1:0] EdgeLast = EW'(2 * DATA_W - 1);
   localparam logic [EW-1:0] EdgeEnd  = EW'(2 * DATA_W);

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [EW-1:0]     edge_q, edge_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [CSW-1:0]    cs_q, cs_d;
   logic              cpha_q, cpha_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              done_q, done_d;
   logic              do_edge, leading, sample_bit, sel_ok;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = bus.miso;
   assign sample_bit  = mosi_q;
`else
   assign sample_bit  = bus.miso;
`endif

   assign sel_ok  = 32'(bus.cs_sel) < NUM_CS;
   // Even-numbered sclk edges move away from the idle level.
   assign leading = ~edge_q[0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      cs_d    = cs_q;
      cpha_d  = cpha_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      do_edge = 1'b0;

      unique case (state_q)
         StIdle: begin
            sclk_d = bus.cpol;
            // done_q blocks a start in the completion cycle.
            if (bus.start && sel_ok && !done_q) begin
               state_d = StSetup;
               cnt_d   = '0;
               edge_d  = '0;
               rx_d    = '0;
               cs_d    = bus.cs_sel;
               cpha_d  = bus.cpha;
               if (bus.cpha) begin
                  tx_d = bus.din_master;
               end else begin
                  mosi_d = bus.din_master[DATA_W-1];
                  tx_d   = bus.din_master << 1;
               end
            end
         end
         StSetup: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DivLast) begin
               state_d = StXfer;
               cnt_d   = '0;
               do_edge = 1'b1;
            end
         end
         StXfer: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DivLast) begin
               cnt_d = '0;
               if (edge_q == EdgeEnd) begin
                  state_d = StHold;
               end else begin
                  do_edge = 1'b1;
               end
            end
         end
         StHold: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DivLast) begin
               state_d = StIdle;
               done_d  = 1'b1;
               dout_d  = rx_q;
            end
         end
         default: state_d = StIdle;
      endcase

      if (do_edge) begin
         edge_d = edge_q + 1'b1;
         sclk_d = ~sclk_q;
         if (cpha_q ? !leading : leading) begin
            rx_d = {rx_q[DATA_W-2:0], sample_bit};
         end
         // cpha=0 never shifts after the final trailing edge.
         if (cpha_q ? leading : (!leading && edge_q != EdgeLast)) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         cs_q    <= '0;
         cpha_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         cs_q    <= cs_d;
         cpha_q  <= cpha_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
      end
   end

   assign bus.sclk        = sclk_q;
   assign bus.mosi        = mosi_q;
   assign bus.done        = done_q;
   assign bus.dout_master = dout_q;
   assign bus.busy        = (state_q != StIdle);
   assign bus.cs_n        = (state_q == StIdle) ? '1 : ~(NUM_CS'(1) << cs_q);
endmodule

// File: tb/tb_spi_master_cfg.sv
// Randomised bench for spi_master_cfg: an SPI slave model plus word-level expectations.
// A second instance with NUM_CS=3 covers the out-of-range chip-select case.
module tb_spi_master_cfg;
   localparam int unsigned DW  = 8;
   localparam int unsigned CD  = 2;
   localparam int unsigned NC  = 4;
   localparam int unsigned LAT = 1 + CD * (2 * DW + 2);

   logic mclk = 1'b0;
   logic rst  = 1'b0;
   always #5 mclk = ~mclk;

   spi_master_cfg_if #(.DATA_W(DW), .NUM_CS(NC)) bus ();
   spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(NC)) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   spi_master_cfg_if #(.DATA_W(DW), .NUM_CS(3)) bus3 ();
   spi_master_cfg #(.DATA_W(DW), .CLK_DIV(1), .NUM_CS(3)) dut3 (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus3)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // SPI slave: returns slv_ret MSB first, collects mosi into slv_rx.
   logic [DW-1:0] slv_ret = '0;
   logic [DW-1:0] slv_rx  = '0;
   logic          slv_cpol = 1'b0;
   logic          slv_cpha = 1'b0;
   int            slv_bit  = 0;
   logic          prev_sclk = 1'b0;
   logic          prev_act  = 1'b0;
   logic          slv_act;

   always @(negedge mclk) begin
      slv_act = (bus.cs_n != '1);
      if (!rst) begin
         bus.miso = 1'b0;
      end else if (slv_act && !prev_act) begin
         slv_bit = 0;
         slv_rx  = '0;
         if (!slv_cpha) bus.miso = slv_ret[DW-1];
      end else if (slv_act && prev_act && bus.sclk != prev_sclk) begin
         if (bus.sclk != slv_cpol) begin
            if (!slv_cpha) slv_rx = {slv_rx[DW-2:0], bus.mosi};
            else if (slv_bit < DW) bus.miso = slv_ret[DW-1-slv_bit];
         end else begin
            if (slv_cpha) slv_rx = {slv_rx[DW-2:0], bus.mosi};
            slv_bit++;
            if (!slv_cpha && slv_bit < DW) bus.miso = slv_ret[DW-1-slv_bit];
         end
      end
      prev_sclk = bus.sclk;
      prev_act  = slv_act;
   end

   function automatic logic [DW-1:0] exp_rx(input logic [DW-1:0] din, input logic [DW-1:0] ret);
`ifdef SPI_LOOPBACK_EN
      return din;
`else
      return ret;
`endif
   endfunction

   function automatic logic [NC-1:0] exp_cs(input int sel);
      logic [NC-1:0] v;
      v      = '1;
      v[sel] = 1'b0;
      return v;
   endfunction

   task automatic run_xfer(input logic [DW-1:0] din, input logic [DW-1:0] ret, input logic cp,
                           input logic ch, input int sel, input string tag);
      int n;
      bit got_done;
      @(negedge mclk);
      bus.cpol   = cp;
      bus.cpha   = ch;
      bus.cs_sel = 2'(sel);
      slv_cpol   = cp;
      slv_cpha   = ch;
      slv_ret    = ret;
      @(negedge mclk);
      check_eq({tag, "_idle_sclk"}, 32'(bus.sclk), 32'(cp));
      bus.din_master = din;
      bus.start      = 1'b1;
      n        = 0;
      got_done = 1'b0;
      while (!got_done && n < 4 * LAT) begin
         @(negedge mclk);
         n++;
         bus.start = 1'b0;
         if (n == 1) begin
            check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check_eq({tag, "_cs"}, 32'(bus.cs_n), 32'(exp_cs(sel)));
         end
         if (n == 2) begin
            // Everything latched at start; these must be ignored.
            bus.din_master = ~din;
            bus.cpol       = ~cp;
            bus.cpha       = ~ch;
            bus.cs_sel     = 2'(sel + 1);
         end
         if (n == LAT / 2) check_eq({tag, "_cs_mid"}, 32'(bus.cs_n), 32'(exp_cs(sel)));
         if (bus.done) got_done = 1'b1;
      end
      check_eq({tag, "_done"}, 32'(got_done), 32'd1);
      check_eq({tag, "_lat"}, 32'(n), 32'(LAT));
      check_eq({tag, "_dout"}, 32'(bus.dout_master), 32'(exp_rx(din, ret)));
      check_eq({tag, "_mosi"}, 32'(slv_rx), 32'(din));
      check_eq({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      check_eq({tag, "_cs_end"}, 32'(bus.cs_n), 32'({NC{1'b1}}));
      check_eq({tag, "_sclk_end"}, 32'(bus.sclk), 32'(cp));
      @(negedge mclk);
      check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check_eq({tag, "_dout_hold"}, 32'(bus.dout_master), 32'(exp_rx(din, ret)));
   endtask

   initial begin
      int n, d1, d2, low_cnt;
      bit seen;

      bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.cs_sel = '0; bus.din_master = '0;
      bus3.start = 1'b0; bus3.cpol = 1'b0; bus3.cpha = 1'b0; bus3.cs_sel = '0;
      bus3.din_master = '0; bus3.miso = 1'b0;
      repeat (3) @(negedge mclk);
      check_eq("rst_sclk", 32'(bus.sclk), 32'd0);
      check_eq("rst_mosi", 32'(bus.mosi), 32'd0);
      check_eq("rst_cs", 32'(bus.cs_n), 32'({NC{1'b1}}));
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_dout", 32'(bus.dout_master), 32'd0);
      rst = 1'b1;

      run_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 2, "mode0");
      run_xfer(8'hA5, 8'h3C, 1'b0, 1'b1, 3, "mode1");
      run_xfer(8'hA5, 8'h3C, 1'b1, 1'b0, 0, "mode2");
      run_xfer(8'hA5, 8'h3C, 1'b1, 1'b1, 1, "mode3");

      // Reset in the middle of XFER.
      @(negedge mclk);
      bus.cpol = 1'b0; bus.cpha = 1'b0; bus.cs_sel = 2'd1; bus.din_master = 8'h96;
      slv_cpol = 1'b0; slv_cpha = 1'b0;
      @(negedge mclk);
      bus.start = 1'b1;
      repeat (12) @(negedge mclk);
      bus.start = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_eq("arst_cs", 32'(bus.cs_n), 32'({NC{1'b1}}));
      check_eq("arst_sclk", 32'(bus.sclk), 32'd0);
      check_eq("arst_busy", 32'(bus.busy), 32'd0);
      check_eq("arst_dout", 32'(bus.dout_master), 32'd0);
      seen = 1'b0;
      repeat (2) begin
         @(negedge mclk);
         seen |= bus.done;
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge mclk);
         seen |= bus.done;
      end
      check_eq("arst_no_done", 32'(seen), 32'd0);
      run_xfer(8'h5A, 8'hC6, 1'b0, 1'b0, 1, "post_rst");

      for (int i = 0; i < 10; i++) begin
         run_xfer(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(NC - 1, 0)), $sformatf("rnd%0d", i));
      end

      // start held high: second start is accepted the cycle after done.
      @(negedge mclk);
      bus.cpol = 1'b0; bus.cpha = 1'b1; bus.cs_sel = 2'd2;
      slv_cpol = 1'b0; slv_cpha = 1'b1; slv_ret = 8'h81;
      @(negedge mclk);
      bus.din_master = 8'h3D;
      bus.start = 1'b1;
      n = 0; d1 = -1; d2 = -1; low_cnt = 0;
      while (d2 < 0 && n < 4 * LAT) begin
         @(negedge mclk);
         n++;
         if (n == 3) bus.din_master = 8'hE2;
         if (d1 >= 0 && !bus.busy && !bus.done) low_cnt++;
         if (bus.done) begin
            if (d1 < 0) begin
               d1 = n;
               check_eq("b2b_mosi1", 32'(slv_rx), 32'h3D);
               check_eq("b2b_dout1", 32'(bus.dout_master), 32'(exp_rx(8'h3D, 8'h81)));
            end else begin
               d2 = n;
            end
         end
      end
      bus.start = 1'b0;
      check_eq("b2b_lat1", 32'(d1), 32'(LAT));
      check_eq("b2b_gap", 32'(d2 - d1), 32'(LAT + 1));
      check_eq("b2b_idle", 32'(low_cnt), 32'd1);
      check_eq("b2b_mosi2", 32'(slv_rx), 32'hE2);
      check_eq("b2b_dout2", 32'(bus.dout_master), 32'(exp_rx(8'hE2, 8'h81)));

      // NUM_CS=3: cs_sel=3 is out of range.
      @(negedge mclk);
      bus3.cs_sel = 2'd3; bus3.din_master = 8'hC3; bus3.start = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge mclk);
         seen |= bus3.busy | bus3.done | (bus3.cs_n != 3'b111);
      end
      check_eq("cs3_ignored", 32'(seen), 32'd0);
      bus3.cs_sel = 2'd2;
      @(negedge mclk);
      bus3.start = 1'b0;
      check_eq("cs3_sel2_busy", 32'(bus3.busy), 32'd1);
      check_eq("cs3_sel2_cs", 32'(bus3.cs_n), 32'b011);
      n = 1;
      while (!bus3.done && n < 100) begin
         @(negedge mclk);
         n++;
      end
      check_eq("cs3_lat", 32'(n), 32'(1 + 1 * (2 * DW + 2)));
      check_eq("cs3_dout", 32'(bus3.dout_master), 32'(exp_rx(8'hC3, 8'h00)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
